// File: rtl/uart_echo_fifo.sv
// UART loopback: checked RX frames are buffered in a FIFO and retransmitted on uart_txd.
// RX and TX each latch baud_sel at their own frame start.
module uart_echo_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   baud_sel,
    input  logic                         uart_rxd,
    output logic                         uart_txd,
    output logic [DATA_BITS-1:0]         rx_dout,
    output logic                         rx_vld,
    output logic                         tx_busy,
    output logic                         frame_err,
    output logic                         parity_err,
    output logic                         ovf,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_cnt
);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int PW      = AW + 1;
    localparam int CW      = $clog2(CLK_FREQ / 9600 + 1);
    localparam int HAS_PAR = (PARITY != 0) ? 1 : 0;
    localparam int TX_BITS = 1 + DATA_BITS + HAS_PAR + STOP_BITS;
    localparam int BW      = $clog2(TX_BITS);

    function automatic logic [CW-1:0] div_of(input logic [1:0] sel);
        case (sel)
            2'd0:    return CW'(CLK_FREQ / 9600);
            2'd1:    return CW'(CLK_FREQ / 19200);
            2'd2:    return CW'(CLK_FREQ / 57600);
            default: return CW'(CLK_FREQ / 115200);
        endcase
    endfunction

    function automatic logic par_of(input logic [DATA_BITS-1:0] d);
        return (^d) ^ (PARITY == 1);
    endfunction

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP} rx_state_t;
    typedef enum logic {T_IDLE, T_SEND} tx_state_t;

    rx_state_t              rx_st, rx_nxt;
    logic                   rx_s1, rx_s2, rx_s3;
    logic [CW-1:0]          rx_div, rx_cnt, rx_tgt;
    logic [BW-1:0]          rx_bit;
    logic [DATA_BITS-1:0]   rx_sh;
    logic                   rx_par, rx_tick, rx_fall, stop_smp, bad_par, good;

    tx_state_t              tx_st, tx_nxt;
    logic [CW-1:0]          tx_div, tx_cnt;
    logic [BW-1:0]          tx_bit;
    logic [TX_BITS-1:0]     tx_sh, frame;
    logic                   tx_tick, tx_last;

    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [DATA_BITS-1:0]   head;
    logic                   push, pop, full;

    assign fifo_cnt = wr_ptr - rd_ptr;

    // ---------------- RX ----------------
    always_comb begin
        rx_nxt  = rx_st;
        rx_tgt  = (rx_st == R_START) ? (rx_div >> 1) : rx_div;
        rx_tick = (rx_cnt == rx_tgt - CW'(1));
        rx_fall = rx_s3 & ~rx_s2;
        case (rx_st)
            R_IDLE:  if (rx_fall) rx_nxt = R_START;
            R_START: if (rx_tick) rx_nxt = rx_s2 ? R_IDLE : R_DATA;
            R_DATA:  if (rx_tick && rx_bit == BW'(DATA_BITS - 1))
                         rx_nxt = (HAS_PAR != 0) ? R_PAR : R_STOP;
            R_PAR:   if (rx_tick) rx_nxt = R_STOP;
            R_STOP:  if (rx_tick) rx_nxt = R_IDLE;
            default: rx_nxt = R_IDLE;
        endcase
        stop_smp = (rx_st == R_STOP) && rx_tick;
        bad_par  = (HAS_PAR != 0) && (rx_par != par_of(rx_sh));
        good     = stop_smp && rx_s2 && !bad_par;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1 <= 1'b1; rx_s2 <= 1'b1; rx_s3 <= 1'b1;
            rx_st <= R_IDLE;
            rx_cnt <= '0; rx_bit <= '0; rx_sh <= '0; rx_par <= 1'b0;
            rx_div <= div_of(2'd3);
            rx_dout <= '0; rx_vld <= 1'b0;
            frame_err <= 1'b0; parity_err <= 1'b0; ovf <= 1'b0;
        end else begin
            rx_s1 <= uart_rxd; rx_s2 <= rx_s1; rx_s3 <= rx_s2;
            rx_st <= rx_nxt;
            // frame error takes priority over parity error
            rx_vld     <= good;
            frame_err  <= stop_smp && !rx_s2;
            parity_err <= stop_smp && rx_s2 && bad_par;
            ovf        <= good && !push;
            if (good) rx_dout <= rx_sh;
            if (rx_st == R_IDLE) begin
                rx_cnt <= '0;
                rx_bit <= '0;
                if (rx_fall) rx_div <= div_of(baud_sel);
            end else if (rx_tick) begin
                rx_cnt <= '0;
                if (rx_st == R_DATA) begin
                    rx_sh  <= {rx_s2, rx_sh[DATA_BITS-1:1]};
                    rx_bit <= rx_bit + BW'(1);
                end
                if (rx_st == R_PAR) rx_par <= rx_s2;
            end else begin
                rx_cnt <= rx_cnt + CW'(1);
            end
        end
    end

    // ---------------- FIFO ----------------
    always_comb begin
        head = mem[rd_ptr[AW-1:0]];
        full = (fifo_cnt == PW'(FIFO_DEPTH));
        pop  = (fifo_cnt != '0) && ((tx_st == T_IDLE) || tx_last);
        push = good && (!full || pop);
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= rx_sh;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // ---------------- TX ----------------
    // whole frame (start, data, parity, stops) is shifted out LSB first
    always_comb begin
        tx_nxt  = tx_st;
        tx_tick = (tx_cnt == tx_div - CW'(1));
        tx_last = (tx_st == T_SEND) && tx_tick && (tx_bit == BW'(TX_BITS - 1));
        case (tx_st)
            T_IDLE:  if (pop) tx_nxt = T_SEND;
            T_SEND:  if (tx_last && !pop) tx_nxt = T_IDLE;
            default: tx_nxt = T_IDLE;
        endcase
        frame                 = '1;
        frame[0]              = 1'b0;
        frame[DATA_BITS:1]    = head;
        if (HAS_PAR != 0) frame[DATA_BITS+1] = par_of(head);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_st <= T_IDLE;
            tx_cnt <= '0; tx_bit <= '0; tx_sh <= '1;
            tx_div <= div_of(2'd3);
            tx_busy <= 1'b0;
            uart_txd <= 1'b1;
        end else begin
            tx_st    <= tx_nxt;
            uart_txd <= (tx_st == T_SEND) ? tx_sh[0] : 1'b1;
            if (pop) begin
                tx_sh   <= frame;
                tx_div  <= div_of(baud_sel);
                tx_cnt  <= '0;
                tx_bit  <= '0;
                tx_busy <= 1'b1;
            end else if (tx_st == T_SEND) begin
                if (tx_last) begin
                    tx_busy <= 1'b0;
                    tx_cnt  <= '0;
                end else if (tx_tick) begin
                    tx_cnt <= '0;
                    tx_bit <= tx_bit + BW'(1);
                    tx_sh  <= {1'b1, tx_sh[TX_BITS-1:1]};
                end else begin
                    tx_cnt <= tx_cnt + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_echo_fifo.sv
// Bench for uart_echo_fifo: even parity, 2 stop bits, 4-deep FIFO, scaled clock so
// the four baud divisors are 240/120/40/20 cycles.
module tb_uart_echo_fifo;
    localparam int CLK_FREQ = 2304000;
    localparam int DB       = 8;
    localparam int SB       = 2;
    localparam int DEPTH    = 4;
    localparam int NB       = 1 + DB + 1 + SB;
    localparam int FAST     = 20;
    localparam int SLOW     = 240;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  baud_sel = 2'd3;
    logic        uart_rxd = 1'b1;
    logic        uart_txd, rx_vld, tx_busy, frame_err, parity_err, ovf;
    logic [DB-1:0] rx_dout;
    logic [2:0]  fifo_cnt;

    uart_echo_fifo #(
        .CLK_FREQ(CLK_FREQ), .DATA_BITS(DB), .PARITY(2), .STOP_BITS(SB), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .baud_sel(baud_sel), .uart_rxd(uart_rxd),
        .uart_txd(uart_txd), .rx_dout(rx_dout), .rx_vld(rx_vld), .tx_busy(tx_busy),
        .frame_err(frame_err), .parity_err(parity_err), .ovf(ovf), .fifo_cnt(fifo_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int div_of(input logic [1:0] s);
        case (s)
            2'd0:    return CLK_FREQ / 9600;
            2'd1:    return CLK_FREQ / 19200;
            2'd2:    return CLK_FREQ / 57600;
            default: return CLK_FREQ / 115200;
        endcase
    endfunction

    // ---------------- observers ----------------
    int cyc = 0;
    int rst_cnt = 0;
    logic [1:0] bs_d1 = 2'd3, bs_d2 = 2'd3;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        bs_d1 <= baud_sel;
        bs_d2 <= bs_d1;
        if (rst) rst_cnt <= rst_cnt + 1;
    end

    int n_vld = 0, n_perr = 0, n_ferr = 0, n_ovf = 0;
    int vld_cyc = 0;
    int vld_fifo = 0;
    logic [DB-1:0] last_dout = '0;
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_vld) begin
                n_vld     <= n_vld + 1;
                last_dout <= rx_dout;
                vld_cyc   <= cyc;
                vld_fifo  <= int'(fifo_cnt);
            end
            if (parity_err) n_perr <= n_perr + 1;
            if (frame_err)  n_ferr <= n_ferr + 1;
            if (ovf)        n_ovf  <= n_ovf + 1;
        end
    end

    // reference model: bytes expected on uart_txd, in order
    logic [DB-1:0] exp_q[$];
    int start_q[$];
    bit mon_on = 1'b0;

    // TX decoder: divisor is the baud_sel in force at the pop, two edges before the start bit
    initial begin : mon
        int d;
        int rs;
        int t0;
        logic [NB-1:0] f;
        wait (mon_on);
        forever begin
            @(negedge clk);
            if (uart_txd == 1'b0) begin
                t0 = cyc;
                d  = div_of(bs_d2);
                rs = rst_cnt;
                repeat (d / 2) @(negedge clk);
                f[0] = uart_txd;
                for (int i = 1; i < NB; i++) begin
                    repeat (d) @(negedge clk);
                    f[i] = uart_txd;
                end
                if (rs == rst_cnt) begin
                    start_q.push_back(t0);
                    check("tx_start_bit", int'(f[0]), 0);
                    check("tx_stop_bits", int'(f[NB-1:NB-2]), 3);
                    check("tx_parity", int'(f[DB+1]), int'(^f[DB:1]));
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL tx_unexpected: got 0x%0h, expected no frame", f[DB:1]);
                    end else begin
                        check("tx_data", int'(f[DB:1]), int'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_frame(input logic [DB-1:0] b, input bit bad_par, input bit bad_stop,
                              input int d);
        logic [NB-1:0] f;
        f           = '1;
        f[0]        = 1'b0;
        f[DB:1]     = b;
        f[DB+1]     = (^b) ^ bad_par;
        f[DB+2]     = ~bad_stop;
        for (int i = 0; i < NB; i++) begin
            uart_rxd = f[i];
            repeat (d) @(negedge clk);
        end
        uart_rxd = 1'b1;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || tx_busy) && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check(name, int'(t < 20000), 1);
        repeat (2) @(negedge clk);
    endtask

    // first TX frame goes out at the slowest rate so later RX bytes pile up in the FIFO
    task automatic send_slow_tx(input logic [DB-1:0] b);
        int t;
        t = 0;
        fork
            send_frame(b, 1'b0, 1'b0, FAST);
            begin
                while (!rx_vld && t < 1000) begin
                    @(negedge clk);
                    t++;
                end
                baud_sel = 2'd0;
                @(negedge clk);
                baud_sel = 2'd3;
            end
        join
        check("slow_vld_seen", int'(t < 1000), 1);
    endtask

    typedef struct {
        logic [DB-1:0] data;
        bit bad_par;
        bit bad_stop;
        bit glitch;
        bit vld;
        bit perr;
        bit ferr;
    } vec_t;

    vec_t vecs[9];

    initial begin : main
        int v0, p0, f0, o0;
        int nexp;
        logic [DB-1:0] b;
        int kind;
        bit bp, bs;

        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'h07, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        // reset state
        repeat (3) @(negedge clk);
        check("rst_txd", int'(uart_txd), 1);
        check("rst_rx_dout", int'(rx_dout), 0);
        check("rst_rx_vld", int'(rx_vld), 0);
        check("rst_tx_busy", int'(tx_busy), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_parity_err", int'(parity_err), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_fifo_cnt", int'(fifo_cnt), 0);
        rst = 1'b0;
        mon_on = 1'b1;
        repeat (5) @(negedge clk);

        // directed table
        for (int i = 0; i < 9; i++) begin
            v0 = n_vld; p0 = n_perr; f0 = n_ferr; o0 = n_ovf;
            if (vecs[i].vld) exp_q.push_back(vecs[i].data);
            if (vecs[i].glitch) begin
                uart_rxd = 1'b0;
                repeat (2) @(negedge clk);
                uart_rxd = 1'b1;
                repeat (3 * FAST) @(negedge clk);
            end else begin
                send_frame(vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop, FAST);
            end
            repeat (2) @(negedge clk);
            check($sformatf("row%0d_vld", i), n_vld - v0, int'(vecs[i].vld));
            check($sformatf("row%0d_perr", i), n_perr - p0, int'(vecs[i].perr));
            check($sformatf("row%0d_ferr", i), n_ferr - f0, int'(vecs[i].ferr));
            check($sformatf("row%0d_ovf", i), n_ovf - o0, 0);
            if (vecs[i].vld) check($sformatf("row%0d_dout", i), int'(last_dout), int'(vecs[i].data));
            drain($sformatf("row%0d_drain", i));
            check($sformatf("row%0d_fifo_empty", i), int'(fifo_cnt), 0);
            check($sformatf("row%0d_txd_idle", i), int'(uart_txd), 1);
            if (i == 0) begin
                check("lat_fifo_at_vld", vld_fifo, 1);
                check("lat_vld_to_start", start_q[start_q.size()-1] - vld_cyc, 2);
            end
        end

        // randomized frames against the model
        nexp = 0;
        v0 = n_vld; p0 = n_perr; f0 = n_ferr; o0 = n_ovf;
        for (int i = 0; i < 24; i++) begin
            b    = DB'($urandom);
            kind = $urandom_range(0, 5);
            bs   = (kind == 0);
            bp   = (kind == 0) || (kind == 1);
            if (!bs && !bp) begin
                exp_q.push_back(b);
                nexp++;
            end
            send_frame(b, bp, bs, FAST);
            check($sformatf("rnd%0d_ferr", i), n_ferr - f0, int'(bs));
            check($sformatf("rnd%0d_perr", i), n_perr - p0, int'(!bs && bp));
            check($sformatf("rnd%0d_vld", i), n_vld - v0, int'(!bs && !bp));
            if (!bs && !bp) check($sformatf("rnd%0d_dout", i), int'(last_dout), int'(b));
            v0 = n_vld; p0 = n_perr; f0 = n_ferr;
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end
        check("rnd_ovf", n_ovf - o0, 0);
        drain("rnd_drain");

        // FIFO fill: first byte transmits slowly, 0x02..0x07 arrive back-to-back
        v0 = n_vld; o0 = n_ovf;
        for (int k = 1; k <= 5; k++) exp_q.push_back(DB'(k));
        send_slow_tx(8'h01);
        for (int k = 2; k <= 7; k++) send_frame(DB'(k), 1'b0, 1'b0, FAST);
        check("fill_fifo_cnt", int'(fifo_cnt), DEPTH);
        check("fill_ovf", n_ovf - o0, 2);
        check("fill_vld", n_vld - v0, 7);
        check("fill_dout", int'(last_dout), 7);
        drain("fill_drain");
        nexp = start_q.size();
        check("fill_gap1", start_q[nexp-4] - start_q[nexp-5], NB * SLOW);
        for (int k = 3; k >= 1; k--)
            check($sformatf("fill_gap_tail%0d", k), start_q[nexp-k] - start_q[nexp-k-1], NB * FAST);

        // baud change during a TX frame only affects the next frame
        exp_q.push_back(8'hC3);
        exp_q.push_back(8'h5A);
        fork
            begin
                send_frame(8'hC3, 1'b0, 1'b0, FAST);
                repeat (100) @(negedge clk);
                send_frame(8'h5A, 1'b0, 1'b0, FAST);
            end
            begin
                nexp = 0;
                while (!tx_busy && nexp < 2000) begin
                    @(negedge clk);
                    nexp++;
                end
                check("baud_busy_seen", int'(nexp < 2000), 1);
                repeat (150) @(negedge clk);
                baud_sel = 2'd0;
            end
        join
        drain("baud_drain");
        check("baud_lat_slow", start_q[start_q.size()-1] - vld_cyc, 2);
        baud_sel = 2'd3;

        // reset during a TX frame with one byte still queued
        send_slow_tx(8'h11);
        send_frame(8'h22, 1'b0, 1'b0, FAST);
        check("prerst_fifo_cnt", int'(fifo_cnt), 1);
        check("prerst_busy", int'(tx_busy), 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_txd", int'(uart_txd), 1);
        check("rst_mid_busy", int'(tx_busy), 0);
        check("rst_mid_fifo", int'(fifo_cnt), 0);
        rst = 1'b0;
        repeat (3000) @(negedge clk);
        v0 = n_vld;
        exp_q.push_back(8'h33);
        send_frame(8'h33, 1'b0, 1'b0, FAST);
        check("postrst_vld", n_vld - v0, 1);
        drain("postrst_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #(10 * 80000);
        $display("FAIL watchdog: run exceeded 80000 cycles, %0d compared / %0d mismatched so far",
                 n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end
endmodule
